neuron_mac: RTL and testbench

Sequential multiply-accumulate stage for one autoencoder neuron. It consumes a stream of signed Q8.8 input/weight pairs and forms each product. Each product is summed into a 16-bit saturating accumulator seeded with a bias. After `N_TERMS` pairs, it presents the pre-activation result to the downstream activation stage over a valid/ready handshake. It sits directly upstream of the activation unit and is the consumer of the 16-bit carry-lookahead adder arithmetic.

---
 rtl/neuron_mac_if.sv | 27 ++
 rtl/neuron_mac.sv | 118 +++++++++++
 tb/tb_neuron_mac.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/neuron_mac_if.sv
// Handshake bundle between a neuron_mac and its producer/consumer.
// master drives operands and out_ready; slave is the MAC itself.
interface neuron_mac_if #(
   parameter int unsigned DATA_W = 16
);
   logic              start;
   logic [DATA_W-1:0] bias;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] x_in;
   logic [DATA_W-1:0] w_in;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] y_out;
   logic              busy;
   logic              sat_flag;

   modport master (
      output start, bias, in_valid, x_in, w_in, out_ready,
      input  in_ready, out_valid, y_out, busy, sat_flag
   );

   modport slave (
      input  start, bias, in_valid, x_in, w_in, out_ready,
      output in_ready, out_valid, y_out, busy, sat_flag
   );
endinterface

// File: rtl/neuron_mac.sv
// Sequential Q-format multiply-accumulate for one neuron: bias plus N_TERMS
// saturated products, handed downstream over a valid/ready handshake.
module neuron_mac #(
   parameter int unsigned N_TERMS = 4,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned FRAC_W  = 8
) (
   input logic         clk,
   input logic         rst_n,
   neuron_mac_if.slave bus
);

   localparam int unsigned CntW  = $clog2(N_TERMS + 1);
   localparam int unsigned ProdW = 2 * DATA_W;

   localparam logic signed [ProdW-1:0] ProdMax = {{(DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
   localparam logic signed [ProdW-1:0] ProdMin = {{(DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};
   localparam logic [DATA_W-1:0]       AccMax  = {1'b0, {(DATA_W - 1){1'b1}}};
   localparam logic [DATA_W-1:0]       AccMin  = {1'b1, {(DATA_W - 1){1'b0}}};
   localparam logic [CntW-1:0]         LastCnt = CntW'(N_TERMS - 1);

   typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              sat_q, sat_d;

   logic signed [ProdW-1:0] x_ext, w_ext, prod_full, prod_shr;
   logic [DATA_W-1:0]       prod_sat;
   logic                    prod_clamp;
   logic [DATA_W:0]         sum;
   logic [DATA_W-1:0]       acc_sum;
   logic                    sum_clamp;
   logic                    accept;

   // Datapath: full product, floor shift, clamp, then 17-bit saturating add.
   always_comb begin
      x_ext      = ProdW'($signed(bus.x_in));
      w_ext      = ProdW'($signed(bus.w_in));
      prod_full  = x_ext * w_ext;
      prod_shr   = prod_full >>> FRAC_W;
      prod_clamp = 1'b0;
      prod_sat   = prod_shr[DATA_W-1:0];
      if (prod_shr > ProdMax) begin
         prod_sat   = AccMax;
         prod_clamp = 1'b1;
      end else if (prod_shr < ProdMin) begin
         prod_sat   = AccMin;
         prod_clamp = 1'b1;
      end
      sum       = {acc_q[DATA_W-1], acc_q} + {prod_sat[DATA_W-1], prod_sat};
      acc_sum   = sum[DATA_W-1:0];
      sum_clamp = 1'b0;
      // Top two bits disagree only when the sum left the representable range.
      if (sum[DATA_W] != sum[DATA_W-1]) begin
         acc_sum   = sum[DATA_W] ? AccMin : AccMax;
         sum_clamp = 1'b1;
      end
   end

   // Next-state and operand bookkeeping.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      sat_d   = sat_q;
      accept  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               acc_d   = bus.bias;
               cnt_d   = '0;
               sat_d   = 1'b0;
               state_d = StAccum;
            end
         end
         StAccum: begin
            accept = bus.in_valid;
            if (accept) begin
               acc_d = acc_sum;
               cnt_d = cnt_q + CntW'(1);
               sat_d = sat_q | prod_clamp | sum_clamp;
               if (cnt_q == LastCnt) state_d = StDone;
            end
         end
         StDone: begin
            if (bus.out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         acc_q   <= '0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
      end
   end

   // Outputs decode only the registered state.
   always_comb begin
      bus.in_ready  = (state_q == StAccum);
      bus.out_valid = (state_q == StDone);
      bus.busy      = (state_q != StIdle);
      bus.y_out     = acc_q;
      bus.sat_flag  = sat_q;
   end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: arithmetic model plus per-cycle output compare.
module tb_neuron_mac;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   logic [15:0] cur_x [4];
   logic [15:0] cur_w [4];
   logic [15:0] exp_y   = 16'h0000;
   logic        exp_sat = 1'b0;

   neuron_mac_if #(.DATA_W(16)) bus ();

   neuron_mac #(.N_TERMS(4), .DATA_W(16), .FRAC_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
      end
   endtask

   // Plain integer arithmetic: floor-shift each product, clamp, add, clamp.
   function automatic void model(input logic [15:0] b, output logic [15:0] y, output bit s);
      int acc, p, q;
      s   = 1'b0;
      acc = int'($signed(b));
      for (int i = 0; i < 4; i++) begin
         p = int'($signed(cur_x[i])) * int'($signed(cur_w[i]));
         q = p >>> 8;
         if (q > 32767)  begin q = 32767;  s = 1'b1; end
         if (q < -32768) begin q = -32768; s = 1'b1; end
         acc = acc + q;
         if (acc > 32767)  begin acc = 32767;  s = 1'b1; end
         if (acc < -32768) begin acc = -32768; s = 1'b1; end
      end
      y = acc[15:0];
   endfunction

   task automatic load(input logic [15:0] x0, w0, x1, w1, x2, w2, x3, w3);
      cur_x[0] = x0; cur_w[0] = w0;
      cur_x[1] = x1; cur_w[1] = w1;
      cur_x[2] = x2; cur_w[2] = w2;
      cur_x[3] = x3; cur_w[3] = w3;
   endtask

   // Every cycle a result is presented it must match the model.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid) begin
         chk("cmp_y", {16'h0, bus.y_out}, {16'h0, exp_y});
         chk("cmp_sat", {31'h0, bus.sat_flag}, {31'h0, exp_sat});
         chk("cmp_no_in_ready", {31'h0, bus.in_ready}, 32'h0);
         chk("cmp_busy", {31'h0, bus.busy}, 32'h1);
      end
   end

   task automatic do_start(input logic [15:0] b);
      @(negedge clk);
      bus.start = 1'b1;
      bus.bias  = b;
      @(negedge clk);
      bus.start = 1'b0;
      chk("start_in_ready", {31'h0, bus.in_ready}, 32'h1);
      chk("start_busy", {31'h0, bus.busy}, 32'h1);
      chk("start_sat_clr", {31'h0, bus.sat_flag}, 32'h0);
      chk("start_acc_bias", {16'h0, bus.y_out}, {16'h0, b});
   endtask

   // Feed n pairs from cur_x/cur_w; returns with the last handshake just past.
   task automatic feed(input int n, input int gap_pct);
      int i = 0;
      int cyc = 0;
      logic ir;
      while (i < n) begin
         if (cyc > 200) begin
            chk("feed_timeout", 32'h1, 32'h0);
            return;
         end
         cyc++;
         if (cyc > 1) @(negedge clk);
         if (int'($urandom_range(0, 99)) < gap_pct) begin
            bus.in_valid = 1'b0;
            bus.x_in     = 16'h7fff;
            bus.w_in     = 16'h7fff;
         end else begin
            bus.in_valid = 1'b1;
            bus.x_in     = cur_x[i];
            bus.w_in     = cur_w[i];
         end
         ir = bus.in_ready;
         chk("accum_no_out_valid", {31'h0, bus.out_valid}, 32'h0);
         @(posedge clk);
         if (bus.in_valid && ir) i++;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic run(input string name, input logic [15:0] b, input int gap_pct,
                      input int hold, input bit pulse_start,
                      input logic [15:0] lit_y, input bit lit_sat);
      logic [15:0] my;
      bit          ms;
      model(b, my, ms);
      chk({name, "_model_y"}, {16'h0, my}, {16'h0, lit_y});
      chk({name, "_model_sat"}, {31'h0, ms}, {31'h0, lit_sat});
      exp_y   = lit_y;
      exp_sat = lit_sat;
      do_start(b);
      feed(4, gap_pct);
      chk({name, "_ov_rise"}, {31'h0, bus.out_valid}, 32'h1);
      chk({name, "_y"}, {16'h0, bus.y_out}, {16'h0, lit_y});
      for (int d = 0; d < hold; d++) begin
         bus.out_ready = 1'b0;
         bus.start     = pulse_start && (d == 2);
         @(negedge clk);
         bus.start = 1'b0;
         chk({name, "_hold_ov"}, {31'h0, bus.out_valid}, 32'h1);
         chk({name, "_hold_y"}, {16'h0, bus.y_out}, {16'h0, lit_y});
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk({name, "_ov_drop"}, {31'h0, bus.out_valid}, 32'h0);
      chk({name, "_idle_busy"}, {31'h0, bus.busy}, 32'h0);
      @(negedge clk);
      chk({name, "_idle_in_ready"}, {31'h0, bus.in_ready}, 32'h0);
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.bias      = 16'h0;
      bus.in_valid  = 1'b0;
      bus.x_in      = 16'h0;
      bus.w_in      = 16'h0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_y", {16'h0, bus.y_out}, 32'h0);
      chk("rst_flags", {28'h0, bus.in_ready, bus.out_valid, bus.busy, bus.sat_flag}, 32'h0);
      rst_n = 1'b1;

      load(16'h0100, 16'h0200, 16'h0100, 16'h0200, 16'h0100, 16'h0200, 16'h0100, 16'h0200);
      run("basic", 16'h0000, 0, 0, 1'b0, 16'h0800, 1'b0);

      load(16'h0100, 16'h4000, 16'h0100, 16'h4000, 16'h0100, 16'h4000, 16'h0100, 16'h4000);
      run("possat", 16'h7000, 0, 0, 1'b0, 16'h7fff, 1'b1);

      load(16'hff00, 16'h7fff, 16'hff00, 16'h7fff, 16'hff00, 16'h7fff, 16'hff00, 16'h7fff);
      run("negsat", 16'h8000, 0, 0, 1'b0, 16'h8000, 1'b1);

      load(16'h0001, 16'h0080, 16'hffff, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      run("trunc", 16'h0000, 0, 0, 1'b0, 16'hffff, 1'b0);

      // Product clamp both ways, sum lands back in range.
      load(16'h7fff, 16'h7fff, 16'h8000, 16'h7fff, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      run("psat", 16'h0000, 0, 0, 1'b0, 16'hffff, 1'b1);

      load(16'h0100, 16'h0200, 16'h0100, 16'h0200, 16'h0100, 16'h0200, 16'h0100, 16'h0200);
      run("gaps", 16'h0000, 50, 0, 1'b0, 16'h0800, 1'b0);
      run("stall", 16'h0000, 0, 5, 1'b1, 16'h0800, 1'b0);

      // Abort a saturating run after two pairs.
      load(16'h0100, 16'h4000, 16'h0100, 16'h4000, 16'h0100, 16'h4000, 16'h0100, 16'h4000);
      exp_y   = 16'h7fff;
      exp_sat = 1'b1;
      do_start(16'h7000);
      feed(2, 0);
      chk("pre_rst_sat", {31'h0, bus.sat_flag}, 32'h1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_y", {16'h0, bus.y_out}, 32'h0);
      chk("midrst_flags", {28'h0, bus.in_ready, bus.out_valid, bus.busy, bus.sat_flag}, 32'h0);
      load(16'h0100, 16'h0200, 16'h0100, 16'h0200, 16'h0100, 16'h0200, 16'h0100, 16'h0200);
      run("postrst", 16'h0000, 0, 0, 1'b0, 16'h0800, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
